// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter; issues a one-cycle start pulse per byte when the transmitter is idle.
// Push-to-start latency 1 cycle after the write edge; pushes into a full FIFO are dropped and flagged sticky.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [7:0]    i_wr_data,
  input  logic          i_clr_ovf,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_overflow,
  output logic          o_tx_start,
  output logic [7:0]    o_tx_data,
  input  logic          i_tx_busy,
  output logic          o_idle
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  state_t        state, state_nx;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign o_count = count;
  assign o_full  = (count == CNT_MAX);
  assign o_empty = (count == '0);
  assign push    = i_wr_en && !o_full;
  assign o_idle  = o_empty && (state == S_IDLE) && !i_tx_busy;

  // i_tx_busy already covers our own start pulse, so S_WAIT cannot exit early.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!o_empty && !i_tx_busy) begin
          pop      = 1'b1;
          state_nx = S_START;
        end
      end
      S_START: state_nx = S_WAIT;
      S_WAIT:  if (!i_tx_busy) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_data  <= 8'h00;
    end else begin
      state      <= state_nx;
      o_tx_start <= pop;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        o_tx_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (i_wr_en && o_full) o_overflow <= 1'b1;
      else if (i_clr_ovf)    o_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model compared every cycle, plus a simple transmitter model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       full, empty, overflow, tx_start, idle;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       busy;
  logic       force_busy = 1'b0;
  int         txcnt = 0;
  int         frame_len = 2170;

  int total = 0;
  int bad = 0;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_clr_ovf(clr_ovf), .o_full(full), .o_empty(empty), .o_count(count),
    .o_overflow(overflow), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .i_tx_busy(busy), .o_idle(idle)
  );

  always #5 clk = ~clk;

  // Transmitter: busy during its start input and for frame_len cycles after; never reset by the FIFO.
  always @(posedge clk) begin
    if (tx_start) txcnt <= frame_len;
    else if (txcnt > 0) txcnt <= txcnt - 1;
  end
  assign busy = tx_start | (txcnt != 0) | force_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue, a sticky flag, and a "dispatcher armed" flag that
  // drops on every start and re-arms once the transmitter has been seen idle.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_armed = 1'b1;
  logic       m_start = 1'b0;
  logic [7:0] m_data = 8'h00;

  logic [7:0] out_log[$];
  int         cyc = 0;
  int         last_start = 0;
  logic       spacing_on = 1'b0;

  always @(negedge clk) begin
    logic full_pre;
    logic go;
    cyc++;
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("tx_start", 32'(tx_start), 32'(m_start));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    chk("idle", 32'(idle), 32'(mq.size() == 0 && m_armed && !busy));
    if (tx_start === 1'b1) begin
      if (spacing_on) chk("start_gap_ok", 32'((cyc - last_start) >= 2170), 32'd1);
      last_start = cyc;
      out_log.push_back(tx_data);
    end
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_armed = 1'b1;
      m_start = 1'b0;
      m_data = 8'h00;
    end else begin
      full_pre = (mq.size() == DEPTH);
      go = m_armed && (mq.size() > 0) && !busy;
      m_start = go;
      if (go) begin
        m_data = mq.pop_front();
        m_armed = 1'b0;
      end else if (!m_armed && !busy) begin
        m_armed = 1'b1;
      end
      if (wr_en && full_pre) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      if (wr_en && !full_pre) mq.push_back(wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (!(idle && mq.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(idle), 32'd1);
  endtask

  initial begin
    int base;
    int n;
    logic [7:0] d;
    logic [7:0] sent[$];

    repeat (3) tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    tick();

    // Single byte: start pulse on the second edge counting the write edge.
    push_byte(8'hA5);
    chk("t1_count_after_push", 32'(count), 32'd1);
    chk("t1_no_start_yet", 32'(tx_start), 32'd0);
    tick();
    chk("t1_start", 32'(tx_start), 32'd1);
    chk("t1_data", 32'(tx_data), 32'hA5);
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    tick();
    chk("t1_start_drop", 32'(tx_start), 32'd0);

    // Fill while busy, then overflow and clear.
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_count", 32'(count), 32'd16);
    push_byte(8'hFF);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_count_hold", 32'(count), 32'd16);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t2_ovf_clr", 32'(overflow), 32'd0);

    // Drain at 10 bits x 217 cycles per frame.
    spacing_on = 1'b1;
    force_busy = 1'b0;
    n = 0;
    while (!(out_log.size() >= 17 && idle) && n < 40000) begin
      tick();
      n++;
    end
    spacing_on = 1'b0;
    chk("t3_out_count", 32'(out_log.size()), 32'd17);
    if (out_log.size() >= 17)
      for (int i = 0; i < 16; i++) chk("t3_order", 32'(out_log[i+1]), 32'(i));
    chk("t3_idle", 32'(idle), 32'd1);

    // Full FIFO: pop and dropped push on the same edge.
    frame_len = 20;
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'($urandom));
    chk("t4_full", 32'(full), 32'd1);
    force_busy = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_count", 32'(count), 32'd15);
    chk("t4_start", 32'(tx_start), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    wait_idle(2000, "t4_drain_idle");

    // Steady random traffic across pointer wrap.
    frame_len = 60;
    base = out_log.size();
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      sent.push_back(d);
      push_byte(d);
      repeat ($urandom_range(44, 54)) tick();
    end
    wait_idle(5000, "t5_drain_idle");
    chk("t5_out_count", 32'(out_log.size() - base), 32'd40);
    if (out_log.size() - base == 40)
      for (int i = 0; i < 40; i++) chk("t5_order", 32'(out_log[base+i]), 32'(sent[i]));

    // Reset while waiting on the transmitter with 5 bytes queued.
    frame_len = 300;
    force_busy = 1'b1;
    for (int i = 0; i < 6; i++) push_byte(8'(8'h30 + i));
    force_busy = 1'b0;
    repeat (5) tick();
    chk("t6_queued", 32'(count), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_start", 32'(tx_start), 32'd0);
    base = out_log.size();
    repeat (20) tick();
    chk("t6_no_start", 32'(out_log.size()), 32'(base));
    push_byte(8'hC3);
    n = 0;
    while (out_log.size() == base && n < 600) begin
      tick();
      n++;
    end
    chk("t6_restart", 32'(out_log.size()), 32'(base + 1));
    if (out_log.size() > base) chk("t6_data", 32'(out_log[base]), 32'hC3);
    wait_idle(1000, "t6_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and dispatcher that sits directly upstream of the UART transmitter. Debugger logic pushes response bytes at any rate. The block stores them in a circular FIFO and feeds them to the transmitter one at a time, issuing a one-cycle start pulse only when the transmitter reports not-busy. It decouples the command/response engine from the serial bit rate.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous active-high reset
i_wr_en  input  1  push request, one byte per asserted cycle
i_wr_data  input  8  byte to push
i_clr_ovf  input  1  clears o_overflow
o_full  output  1  FIFO holds DEPTH bytes
o_empty  output  1  FIFO holds 0 bytes
o_count  output  AW+1  bytes currently stored
o_overflow  output  1  sticky: a push was dropped because the FIFO was full
o_tx_start  output  1  start pulse to transmitter (registered)
o_tx_data  output  8  byte to transmitter (registered, valid while o_tx_start high)
i_tx_busy  input  1  transmitter busy; combinationally includes its own start input
o_idle  output  1  FIFO empty and dispatcher in S_IDLE and i_tx_busy low

Behaviour:
- One clock; reset is synchronous, active-high, named i_rst; all state registers reset on i_clk edge with i_rst=1.
- Reset values: rd/wr pointers 0, o_count 0, o_empty 1, o_full 0, o_overflow 0, o_tx_start 0, o_tx_data 8'h00, state S_IDLE. Reset mid-transfer discards stored bytes. The transmitter is not reset by this block and finishes its current frame. The dispatcher waits for i_tx_busy low before the next dispatch.
- Storage: DEPTH x 8 array, AW-bit pointers wrapping modulo DEPTH. o_count is the registered occupancy. o_full = (o_count==DEPTH), o_empty = (o_count==0).
- Push: accepted iff i_wr_en && !o_full in that cycle. Data is written at wr_ptr and wr_ptr increments. A push while o_full is dropped, even if a pop occurs the same cycle, and sets o_overflow. o_overflow clears only on i_rst or i_clr_ovf. If a drop and i_clr_ovf coincide, set wins.
- Pop: occurs only on dispatch (see FSM). Simultaneous accepted push and pop leaves o_count unchanged.
- Push to empty FIFO: the byte is visible to the dispatcher next cycle (write-to-dispatch min latency 1 cycle, i.e. o_tx_start high 2 edges after the push edge).
- Dispatcher FSM:
  - S_IDLE: if !o_empty && !i_tx_busy, then o_tx_data <= mem[rd_ptr], o_tx_start <= 1, rd_ptr++, count--, go S_START. Otherwise stay.
  - S_START: o_tx_start high for exactly this one cycle. Next edge: o_tx_start <= 0, go S_WAIT.
  - S_WAIT: stay while i_tx_busy=1. When i_tx_busy=0, go S_IDLE.
  - The S_WAIT stage guarantees no second start while the transmitter is still sending.
- Back-to-back throughput: one byte per transmitter frame plus 2 cycles of dispatch overhead.
- o_tx_data holds the last dispatched byte until the next dispatch.
- o_count width AW+1 so DEPTH itself is representable; no arithmetic wrap on count.

Test Plan:
1. Reset, push 8'hA5 once, i_tx_busy=0 -> o_tx_start=1 for exactly 1 cycle with o_tx_data=8'hA5, 2 edges after the push edge; o_count returns to 0, o_empty=1.
2. Hold i_tx_busy=1, push 16 bytes 8'h00..8'h0F -> o_full=1, o_count=16, no o_tx_start; push 8'hFF -> dropped, o_overflow=1; pulse i_clr_ovf -> o_overflow=0.
3. Release busy with the bench transmitter model (10 bits x 217 cycles) -> bytes emerge in order 8'h00..8'h0F, each start separated by at least 2170 cycles, never while busy; o_idle=1 at end.
4. FIFO full and dispatch pop in the same cycle as a push -> push dropped, o_overflow=1, o_count=15 after the edge.
5. Steady pushes every 50 cycles interleaved with pops across pointer wrap (40 bytes through DEPTH=16) -> output sequence equals input sequence, o_count never exceeds 16.
6. Assert i_rst during S_WAIT with 5 bytes queued -> next cycle o_count=0, o_empty=1, o_tx_start=0; no new start until a fresh push and i_tx_busy low.
